// File: rtl/kick_resolver_pkg.sv
// Shared types and constants for the kick resolver: piece descriptor, kick table
// and FSM state encoding.
package kick_resolver_pkg;

  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 20;
  localparam int KICK_N_I    = 5;
  localparam int KICK_N      = 3;
  localparam int POS_W       = 6;
  localparam int SUM_W       = 7;

  // Horizontal offsets, tried in index order; non-I pieces use the first KICK_N.
  localparam logic signed [SUM_W-1:0] KICK_DX [KICK_N_I] =
    '{7'sd0, -7'sd1, 7'sd1, -7'sd2, 7'sd2};

  typedef enum logic [2:0] {
    SHAPE_I, SHAPE_O, SHAPE_T, SHAPE_S, SHAPE_Z, SHAPE_J, SHAPE_L
  } shape_t;

  typedef struct packed {
    shape_t           shape;
    logic [3:0][15:0] data;
  } tetromino_t;

  typedef struct packed {
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
  } coord_t;

  typedef struct packed {
    tetromino_t tetromino;
    logic [1:0] rotation;
    coord_t     coordinate;
  } tetromino_ctrl;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} kick_state_t;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [POS_W-1:0] v);
    return {{(SUM_W-POS_W){v[POS_W-1]}}, v};
  endfunction

  function automatic logic [3:0] row_nibble(input logic [15:0] mask, input logic [1:0] r);
    logic [3:0][3:0] rows;
    rows = mask;
    return rows[2'd3 - r];
  endfunction

endpackage

// File: rtl/kick_resolver_row_fit_check.sv
// Combinational collision test of one 4-cell mask row against one board row.
module row_fit_check
  import kick_resolver_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H
) (
  input  logic [3:0]              nibble,
  input  logic signed [SUM_W-1:0] col_base,
  input  logic signed [SUM_W-1:0] board_row,
  input  logic [BOARD_W-1:0]      row_data,
  output logic                    hit
);

  localparam int COL_W = $clog2(BOARD_W);
  localparam logic signed [SUM_W-1:0] W_S = SUM_W'(BOARD_W);
  localparam logic signed [SUM_W-1:0] H_S = SUM_W'(BOARD_H);

  logic signed [SUM_W-1:0] cols [4];

  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < 4; c++) cols[c] = col_base + SUM_W'(c);
    // Rows above the board are hidden spawn space and never collide.
    if (nibble != 4'd0 && !board_row[SUM_W-1]) begin
      if (board_row >= H_S) hit = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (nibble[3-c]) begin
          if (cols[c][SUM_W-1] || cols[c] >= W_S) hit = 1'b1;
          else if (board_row < H_S && row_data[cols[c][COL_W-1:0]]) hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kick_resolver.sv
// Scans the board under a rotated candidate, one row per cycle, trying each
// wall-kick offset in order and reporting the first that fits.
module kick_resolver
  import kick_resolver_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  tetromino_ctrl              t_in,
  output logic [$clog2(BOARD_H)-1:0] row_addr,
  input  logic [BOARD_W-1:0]         row_data,
  output logic                       busy,
  output logic                       done,
  output logic                       success,
  output logic [2:0]                 kick_idx,
  output tetromino_ctrl              t_out
);

  localparam int ADDR_W = $clog2(BOARD_H);
  localparam logic signed [SUM_W-1:0] H_S = SUM_W'(BOARD_H);

  kick_state_t             state;
  tetromino_ctrl           cur;
  tetromino_ctrl           t_fit;
  logic [1:0]              row_cnt;
  logic [1:0]              chk_row;
  logic [2:0]              kidx;
  logic                    acc;
  logic                    chk_en;
  logic                    hit;
  logic                    row_hit;
  logic                    fit;
  logic                    last;
  logic signed [SUM_W-1:0] x_s;
  logic signed [SUM_W-1:0] y_s;
  logic signed [SUM_W-1:0] dx;
  logic signed [SUM_W-1:0] col_base;
  logic signed [SUM_W-1:0] board_row;
  logic [15:0]             mask;
  logic [3:0]              nibble;

  // Rows outside the board are never fetched; address 0 is a harmless dummy.
  function automatic logic [ADDR_W-1:0] row_addr_of(input logic signed [SUM_W-1:0] y,
                                                    input logic [1:0] r);
    logic signed [SUM_W-1:0] br;
    br = y + $signed(SUM_W'(r));
    if (br[SUM_W-1] || br >= H_S) return '0;
    return br[ADDR_W-1:0];
  endfunction

  // The read port has one cycle of latency, so the row checked trails the
  // row addressed by one; DRAIN exists only to check row 3.
  always_comb begin
    mask      = cur.tetromino.data[cur.rotation];
    x_s       = sext(cur.coordinate.x);
    y_s       = sext(cur.coordinate.y);
    dx        = KICK_DX[kidx];
    col_base  = x_s + dx;
    chk_en    = (state == DRAIN) || (state == READ && row_cnt != 2'd0);
    chk_row   = (state == DRAIN) ? 2'd3 : row_cnt - 2'd1;
    nibble    = row_nibble(mask, chk_row);
    board_row = y_s + $signed(SUM_W'(chk_row));
    last      = (cur.tetromino.shape == SHAPE_I) ? (kidx == 3'(KICK_N_I - 1))
                                                 : (kidx == 3'(KICK_N - 1));
    t_fit              = cur;
    t_fit.coordinate.x = col_base[POS_W-1:0];
  end

  row_fit_check #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_fit (
    .nibble    (nibble),
    .col_base  (col_base),
    .board_row (board_row),
    .row_data  (row_data),
    .hit       (hit)
  );

  assign row_hit = chk_en & hit;
  assign fit     = ~(acc | row_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      row_cnt  <= '0;
      kidx     <= '0;
      acc      <= 1'b0;
      row_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
      kick_idx <= '0;
      t_out    <= '0;
    end else begin
      done    <= 1'b0;
      success <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            cur      <= t_in;
            kidx     <= '0;
            acc      <= 1'b0;
            row_cnt  <= '0;
            row_addr <= row_addr_of(sext(t_in.coordinate.y), 2'd0);
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          acc <= acc | row_hit;
          if (row_cnt == 2'd3) begin
            state <= DRAIN;
          end else begin
            row_cnt  <= row_cnt + 2'd1;
            row_addr <= row_addr_of(y_s, row_cnt + 2'd1);
          end
        end
        DRAIN: begin
          if (fit || last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            success  <= fit;
            kick_idx <= kidx;
            t_out    <= fit ? t_fit : cur;
          end else begin
            kidx     <= kidx + 3'd1;
            acc      <= 1'b0;
            row_cnt  <= '0;
            row_addr <= row_addr_of(y_s, 2'd0);
            state    <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kick_resolver.sv
// Scoreboarded bench for kick_resolver: directed cases plus randomized pieces and boards.
module tb_kick_resolver;
  import kick_resolver_pkg::*;

  localparam int W = 10;
  localparam int H = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  tetromino_ctrl t_in;
  logic [4:0]    row_addr;
  logic [W-1:0]  row_data;
  logic          busy;
  logic          done;
  logic          success;
  logic [2:0]    kick_idx;
  tetromino_ctrl t_out;

  logic [W-1:0] board [H];

  typedef struct {
    logic          success;
    logic [2:0]    kidx;
    tetromino_ctrl tout;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  kick_resolver #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .t_in     (t_in),
    .row_addr (row_addr),
    .row_data (row_data),
    .busy     (busy),
    .done     (done),
    .success  (success),
    .kick_idx (kick_idx),
    .t_out    (t_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous-read board memory.
  always @(posedge clk) row_data <= board[row_addr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: actual %0h required %0h", name, act, req);
    else passed++;
  endtask

  function automatic logic [63:0] shape_masks(input shape_t s);
    case (s)
      SHAPE_I: return {16'h4444, 16'h00F0, 16'h2222, 16'h0F00};
      SHAPE_O: return {4{16'h0660}};
      SHAPE_T: return {16'h4C40, 16'h0E40, 16'h4640, 16'h4E00};
      SHAPE_S: return {16'h8C40, 16'h06C0, 16'h4620, 16'h6C00};
      SHAPE_Z: return {16'h4C80, 16'h0C60, 16'h2640, 16'hC600};
      SHAPE_J: return {16'h44C0, 16'h0E20, 16'h6440, 16'h8E00};
      default: return {16'hC440, 16'h0E80, 16'h4460, 16'h2E00};
    endcase
  endfunction

  function automatic tetromino_ctrl mk(input shape_t s, input int rot, input int x, input int y);
    tetromino_ctrl c;
    c = '0;
    c.tetromino.shape = s;
    c.tetromino.data  = shape_masks(s);
    c.rotation        = 2'(rot);
    c.coordinate.x    = 6'(x);
    c.coordinate.y    = 6'(y);
    return c;
  endfunction

  // Reference: try each offset over every set cell of the 4x4 mask.
  function automatic exp_t model(input tetromino_ctrl c);
    exp_t        e;
    int          dxs[5] = '{0, -1, 1, -2, 2};
    int          n;
    int          bx;
    int          by;
    bit          ok;
    logic [15:0] m;
    n = (c.tetromino.shape == SHAPE_I) ? 5 : 3;
    m = c.tetromino.data[c.rotation];
    e.success = 1'b0;
    e.kidx    = 3'd0;
    e.tout    = c;
    e.lat     = 5 * n;
    e.acc_cyc = 0;
    for (int k = 0; k < n; k++) begin
      ok = 1'b1;
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++)
          if (m[15 - 4*r - cc]) begin
            bx = int'($signed(c.coordinate.x)) + cc + dxs[k];
            by = int'($signed(c.coordinate.y)) + r;
            if (by >= 0) begin
              if (bx < 0 || bx >= W || by >= H) ok = 1'b0;
              else if (board[by][bx]) ok = 1'b0;
            end
          end
      if (ok) begin
        e.success = 1'b1;
        e.kidx    = 3'(k);
        e.tout.coordinate.x = 6'(int'($signed(c.coordinate.x)) + dxs[k]);
        e.lat     = 5 * (k + 1);
        return e;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) check("unexpected_done", 128'(done), 128'(0));
      else begin
        mon_e = q.pop_front();
        check("success", 128'(success), 128'(mon_e.success));
        if (mon_e.success) check("kick_idx", 128'(kick_idx), 128'(mon_e.kidx));
        check("t_out", 128'(t_out), 128'(mon_e.tout));
        check("latency", 128'(cyc - mon_e.acc_cyc), 128'(mon_e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic issue(input tetromino_ctrl c);
    exp_t e;
    wait_idle();
    e = model(c);
    t_in  = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    q.push_back(e);
    start = 1'b0;
    t_in  = mk(SHAPE_L, 3, 0, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(q.size()), 128'(0));
    q.delete();
    @(negedge clk);
  endtask

  task automatic fill_board(input logic [W-1:0] v);
    for (int r = 0; r < H; r++) board[r] = v;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    t_in  = '0;
    fill_board('0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_success", 128'(success), 128'(0));
    check("rst_kick_idx", 128'(kick_idx), 128'(0));
    check("rst_t_out", 128'(t_out), 128'(0));
    check("rst_row_addr", 128'(row_addr), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue(mk(SHAPE_T, 1, 3, 5));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("addr_row%0d", i), 128'(row_addr), 128'(5 + i));
    end
    wait_drain();

    issue(mk(SHAPE_I, 1, 8, 5));
    issue(mk(SHAPE_I, 1, 9, 5));
    wait_drain();

    fill_board(10'h3FF);
    issue(mk(SHAPE_T, 0, 3, 5));
    issue(mk(SHAPE_I, 0, 3, 5));
    wait_drain();
    fill_board('0);

    issue(mk(SHAPE_O, 0, 3, 18));
    issue(mk(SHAPE_O, 0, 3, -1));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("hidden_addr_row%0d", i), 128'(row_addr), 128'((i == 0) ? 0 : i - 1));
    end
    wait_drain();

    // A second start mid-scan and a start during done are both dropped.
    issue(mk(SHAPE_T, 2, 4, 2));
    @(negedge clk);
    @(negedge clk);
    t_in  = mk(SHAPE_I, 0, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_mid_scan", 128'(busy), 128'(1));
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 128'(done), 128'(1));
    t_in  = mk(SHAPE_O, 0, 2, 2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_done_start", 128'(busy), 128'(0));
    repeat (8) @(negedge clk);
    wait_drain();

    // Reset three edges into a scan.
    issue(mk(SHAPE_T, 1, 3, 5));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_t_out", 128'(t_out), 128'(0));
    q.delete();
    @(negedge clk);
    t_in  = mk(SHAPE_T, 1, 3, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_beats_start", 128'(busy), 128'(0));
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(SHAPE_T, 1, 3, 5));
    wait_drain();

    for (int it = 0; it < 40; it++) begin
      wait_idle();
      for (int r = 0; r < H; r++) board[r] = (it % 4 == 0) ? '0 : W'($urandom & $urandom);
      issue(mk(shape_t'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)) - 3, int'($urandom_range(0, 24)) - 4));
    end
    wait_drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
